// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling unit.
package pool_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    FIN
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] signed_max(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters plus incremental source/destination pointers for the pooling walk.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dest_base,
  input  logic [5:0]        col_size,
  input  logic              row_odd,
  input  logic [4:0]        out_rows,
  input  logic [4:0]        out_cols,
  output logic [ADDR_W-1:0] win_addr,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              last_window,
  output logic              last_all
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [4:0]        col_q, col_d, row_q, row_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, win_q, win_d, dst_q, dst_d;
  logic [ADDR_W-1:0] stride1, stride2, row_next, ch_next;
  logic              col_end, row_end;

  assign stride1  = ADDR_W'(col_size);
  assign stride2  = stride1 << 1;
  assign row_next = row_base_q + stride2;
  // An odd trailing source row is skipped by adding one extra row stride.
  assign ch_next  = row_next + (row_odd ? stride1 : '0);

  assign col_end     = (col_q == out_cols - 5'd1);
  assign row_end     = (row_q == out_rows - 5'd1);
  assign last_window = col_end && row_end;
  assign last_all    = last_window && (ch_q == CH_W'(NUM_CH - 1));
  assign win_addr    = win_q;
  assign dest_addr   = dst_q;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    ch_d       = ch_q;
    row_base_d = row_base_q;
    win_d      = win_q;
    dst_d      = dst_q;
    if (step) begin
      dst_d = dst_q + ADDR_W'(1);
      if (!col_end) begin
        col_d = col_q + 5'd1;
        win_d = win_q + ADDR_W'(2);
      end else if (!row_end) begin
        col_d      = '0;
        row_d      = row_q + 5'd1;
        row_base_d = row_next;
        win_d      = row_next;
      end else begin
        col_d      = '0;
        row_d      = '0;
        ch_d       = ch_q + CH_W'(1);
        row_base_d = ch_next;
        win_d      = ch_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      row_base_q <= '0;
      win_q      <= '0;
      dst_q      <= '0;
    end else if (clear) begin
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      row_base_q <= src_base;
      win_q      <= src_base;
      dst_q      <= dest_base;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      ch_q       <= ch_d;
      row_base_q <= row_base_d;
      win_q      <= win_d;
      dst_q      <= dst_d;
    end
  end

endmodule

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 max pooling with optional ReLU over NUM_CH channel-major feature maps.
module maxpool_unit
  import pool_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] src_start_address,
  input  logic [ADDR_W-1:0] dest_start_address,
  input  logic [5:0]        src_row_size,
  input  logic [5:0]        src_col_size,
  output logic [ADDR_W-1:0] sram_address,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic [ADDR_W-1:0] dest_address,
  output logic [DATA_W-1:0] dest_writedata,
  output logic              dest_write
);

  function automatic logic signed [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] v,
    input logic                     en
  );
    return (en && v[DATA_W-1]) ? '0 : v;
  endfunction

  pool_state_t state_q, state_d;
  logic [1:0]  sub_q, sub_d;
  logic        done_q, done_d;
  logic        relu_q;
  logic [5:0]  rows_q, cols_q;
  logic        accept, degenerate, gen_step;
  logic [ADDR_W-1:0] win_addr, gen_dest;
  logic        last_window, last_all;

  logic [RD_LAT-1:0] vld_q, first_q, lastf_q;
  logic        issue, ret_vld, ret_first, ret_last;
  logic signed [DATA_W-1:0] rdata, acc_q, cmb;

  logic                     dest_write_q;
  logic [ADDR_W-1:0]        dest_address_q;
  logic signed [DATA_W-1:0] dest_writedata_q;

  assign accept     = (state_q == IDLE) && start;
  assign degenerate = (src_row_size[5:1] == 5'd0) || (src_col_size[5:1] == 5'd0);

  pool_addr_gen #(.NUM_CH(NUM_CH)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .step       (gen_step),
    .src_base   (src_start_address),
    .dest_base  (dest_start_address),
    .col_size   (cols_q),
    .row_odd    (rows_q[0]),
    .out_rows   (rows_q[5:1]),
    .out_cols   (cols_q[5:1]),
    .win_addr   (win_addr),
    .dest_addr  (gen_dest),
    .last_window(last_window),
    .last_all   (last_all)
  );

  // Read order within a window: (0,0), (0,1), (1,0), (1,1).
  assign sram_address = win_addr + (sub_q[1] ? ADDR_W'(cols_q) : '0) + ADDR_W'(sub_q[0]);

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    done_d   = done_q;
    gen_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          sub_d   = '0;
          state_d = degenerate ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        sub_d = sub_q + 2'd1;
        if (sub_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (ret_last) state_d = WRITE;
      end
      WRITE: begin
        gen_step = 1'b1;
        state_d  = (last_window && last_all) ? FIN : ISSUE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FIN) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sub_q   <= '0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
      rows_q  <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      done_q  <= done_d;
      if (accept) begin
        relu_q <= relu_en;
        rows_q <= src_row_size;
        cols_q <= src_col_size;
      end
    end
  end

  // Stage boundary: read tags travel with the SRAM latency.
  assign issue = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      first_q <= '0;
      lastf_q <= '0;
    end else begin
      vld_q[0]   <= issue;
      first_q[0] <= issue && (sub_q == 2'd0);
      lastf_q[0] <= issue && (sub_q == 2'd3);
      for (int n = 1; n < RD_LAT; n++) begin
        vld_q[n]   <= vld_q[n-1];
        first_q[n] <= first_q[n-1];
        lastf_q[n] <= lastf_q[n-1];
      end
    end
  end

  assign ret_vld   = vld_q[RD_LAT-1];
  assign ret_first = ret_vld && first_q[RD_LAT-1];
  assign ret_last  = ret_vld && lastf_q[RD_LAT-1];
  assign rdata     = sram_readdata;
  assign cmb       = ret_first ? rdata : signed_max(acc_q, rdata);

  // Stage boundary: max accumulator and registered write port.
  always_ff @(posedge clk) begin
    if (ret_vld) acc_q <= cmb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dest_write_q     <= 1'b0;
      dest_address_q   <= '0;
      dest_writedata_q <= '0;
    end else begin
      dest_write_q <= ret_last;
      if (ret_last) begin
        dest_address_q   <= gen_dest;
        dest_writedata_q <= relu_clamp(cmb, relu_q);
      end
    end
  end

  assign done           = done_q;
  assign dest_write     = dest_write_q;
  assign dest_address   = dest_address_q;
  assign dest_writedata = dest_writedata_q;

endmodule

// File: tb/tb_maxpool_unit.sv
// Directed/random bench: NUM_CH=1 and NUM_CH=3 units share stimulus and SRAM contents.
module tb_maxpool_unit;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, relu_en;
  logic [11:0] src_start_address, dest_start_address;
  logic [5:0]  src_row_size, src_col_size;
  logic [11:0] sa1, sa3, da1, da3;
  logic [15:0] rd1, rd3, dd1, dd3;
  logic        dw1, dw3, done1, done3;

  logic signed [15:0] mem [4096];
  logic [11:0] a1_p [RD_LAT];
  logic [11:0] a3_p [RD_LAT];

  always @(posedge clk) begin
    a1_p[0] <= sa1;
    a3_p[0] <= sa3;
    for (int n = 1; n < RD_LAT; n++) begin
      a1_p[n] <= a1_p[n-1];
      a3_p[n] <= a3_p[n-1];
    end
  end
  assign rd1 = mem[a1_p[RD_LAT-1]];
  assign rd3 = mem[a3_p[RD_LAT-1]];

  maxpool_unit #(.NUM_CH(1), .RD_LAT(RD_LAT)) dut1 (
    .clk(clk), .reset(reset), .start(start), .done(done1), .relu_en(relu_en),
    .src_start_address(src_start_address), .dest_start_address(dest_start_address),
    .src_row_size(src_row_size), .src_col_size(src_col_size),
    .sram_address(sa1), .sram_readdata(rd1),
    .dest_address(da1), .dest_writedata(dd1), .dest_write(dw1)
  );

  maxpool_unit #(.NUM_CH(3), .RD_LAT(RD_LAT)) dut3 (
    .clk(clk), .reset(reset), .start(start), .done(done3), .relu_en(relu_en),
    .src_start_address(src_start_address), .dest_start_address(dest_start_address),
    .src_row_size(src_row_size), .src_col_size(src_col_size),
    .sram_address(sa3), .sram_readdata(rd3),
    .dest_address(da3), .dest_writedata(dd3), .dest_write(dw3)
  );

  int cyc = 0;
  int last_w1 = 0;
  logic [27:0] w1[$];
  logic [27:0] w3[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dw1) begin
      w1.push_back({da1, dd1});
      last_w1 <= cyc;
    end
    if (dw3) w3.push_back({da3, dd3});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain window walk over the SRAM image.
  logic [27:0] exp_q[$];

  function automatic void build(input int nch, input int rb, input int db,
                                input int r, input int c, input bit relu);
    int orr, occ, b, m, v, addr;
    int offs [3];
    exp_q.delete();
    orr = r / 2;
    occ = c / 2;
    offs[0] = 1;
    offs[1] = c;
    offs[2] = c + 1;
    for (int ch = 0; ch < nch; ch++)
      for (int i = 0; i < orr; i++)
        for (int j = 0; j < occ; j++) begin
          b = rb + ch * r * c + 2 * i * c + 2 * j;
          m = mem[b % 4096];
          for (int o = 0; o < 3; o++) begin
            v = mem[(b + offs[o]) % 4096];
            if (v > m) m = v;
          end
          if (relu && m < 0) m = 0;
          addr = (db + ch * orr * occ + i * occ + j) % 4096;
          exp_q.push_back({addr[11:0], m[15:0]});
        end
  endfunction

  task automatic cmp(input string tag, input int which);
    logic [27:0] g[$];
    if (which == 1) g = w1;
    else g = w3;
    chk({tag, "_count"}, g.size(), exp_q.size());
    for (int k = 0; k < g.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), 32'(g[k]), 32'(exp_q[k]));
  endtask

  int s, d1c, d3c;

  task automatic run(input int rb, input int db, input int r, input int c,
                     input bit relu, input int restart_at);
    bit s1, s3;
    @(negedge clk);
    src_start_address  = 12'(rb);
    dest_start_address = 12'(db);
    src_row_size       = 6'(r);
    src_col_size       = 6'(c);
    relu_en            = relu;
    start              = 1'b1;
    w1.delete();
    w3.delete();
    s   = cyc;
    s1  = 1'b0;
    s3  = 1'b0;
    d1c = -1;
    d3c = -1;
    for (int n = 1; n < 8000 && !(s1 && s3); n++) begin
      @(negedge clk);
      start = (n == restart_at);
      if (n == 1) begin
        src_start_address  = 12'($urandom);
        dest_start_address = 12'($urandom);
        src_row_size       = 6'($urandom);
        src_col_size       = 6'($urandom);
        relu_en            = ~relu;
      end
      if (!s1 && done1) begin s1 = 1'b1; d1c = cyc - s; end
      if (!s3 && done3) begin s3 = 1'b1; d3c = cyc - s; end
    end
    start = 1'b0;
    chk("done_seen", {30'd0, s1, s3}, 32'd3);
  endtask

  initial begin
    bit seen [int];
    int dups, hi, b;

    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    src_start_address = '0; dest_start_address = '0;
    src_row_size = '0; src_col_size = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_done",      {30'd0, done1, done3}, 32'd0);
    chk("rst_write",     {30'd0, dw1, dw3}, 32'd0);
    chk("rst_sram_addr", {8'd0, sa1, sa3}, 32'd0);
    chk("rst_dest_addr", {8'd0, da1, da3}, 32'd0);
    chk("rst_dest_data", {dd1, dd3}, 32'd0);
    reset = 1'b0;

    // 4x4 ramp: known values and timing
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    run(0, 100, 4, 4, 1'b0, 0);
    chk("t1_last_write_cycle", last_w1 - s, 32'd28);
    chk("t1_done_cycle", d1c, 32'd29);
    chk("t1_first", (w1.size() > 0) ? 32'(w1[0]) : 32'd0, {4'd0, 12'd100, 16'd5});
    chk("t1_fourth", (w1.size() > 3) ? 32'(w1[3]) : 32'd0, {4'd0, 12'd103, 16'd15});
    build(1, 0, 100, 4, 4, 1'b0); cmp("t1_u1", 1);
    build(3, 0, 100, 4, 4, 1'b0); cmp("t1_u3", 3);

    // single negative window, relu off/on
    mem[2000] = -16'sd5; mem[2001] = -16'sd3; mem[2002] = -16'sd8; mem[2003] = -16'sd9;
    run(2000, 300, 2, 2, 1'b0, 0);
    chk("t2_neg", (w1.size() > 0) ? 32'(w1[0]) : 32'd0, {4'd0, 12'd300, 16'hFFFD});
    build(3, 2000, 300, 2, 2, 1'b0); cmp("t2_u3", 3);
    run(2000, 300, 2, 2, 1'b1, 0);
    chk("t2_relu", (w1.size() > 0) ? 32'(w1[0]) : 32'd0, {4'd0, 12'd300, 16'd0});
    build(3, 2000, 300, 2, 2, 1'b1); cmp("t2r_u3", 3);

    // full 26x26 layer on random data
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    run(50, 3000, 26, 26, 1'b0, 0);
    build(3, 50, 3000, 26, 26, 1'b0); cmp("t3_u3", 3);
    build(1, 50, 3000, 26, 26, 1'b0); cmp("t3_u1", 1);
    chk("t3_ch1_base", (w3.size() > 169) ? 32'(w3[169][27:16]) : 32'd0, 32'((3000 + 169) % 4096));
    chk("t3_ch2_base", (w3.size() > 338) ? 32'(w3[338][27:16]) : 32'd0, 32'((3000 + 338) % 4096));
    dups = 0;
    foreach (w3[k]) begin
      if (seen.exists(int'(w3[k][27:16]))) dups++;
      seen[int'(w3[k][27:16])] = 1'b1;
    end
    chk("t3_dups", dups, 32'd0);

    // second start while busy is ignored
    run(50, 3000, 26, 26, 1'b1, 10);
    build(3, 50, 3000, 26, 26, 1'b1); cmp("t4_u3", 3);
    build(1, 50, 3000, 26, 26, 1'b1); cmp("t4_u1", 1);

    // odd 5x5 wrapping past the top of the address space
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r == 4 || c == 4) begin
          b = (4090 + r * 5 + c) % 4096;
          mem[b] = 16'sh7FFF;
        end
    run(4090, 10, 5, 5, 1'b0, 0);
    build(1, 4090, 10, 5, 5, 1'b0); cmp("t5_u1", 1);
    build(3, 4090, 10, 5, 5, 1'b0); cmp("t5_u3", 3);

    // degenerate sizes
    run(0, 0, 1, 8, 1'b0, 0);
    chk("t6_done_u1", d1c, 32'd1);
    chk("t6_done_u3", d3c, 32'd1);
    chk("t6_writes", w1.size() + w3.size(), 32'd0);
    run(0, 0, 8, 1, 1'b0, 0);
    chk("t6b_done_u1", d1c, 32'd1);
    chk("t6b_writes", w1.size() + w3.size(), 32'd0);

    // reset in the middle of a run
    @(negedge clk);
    src_start_address = 12'd7; dest_start_address = 12'd1000;
    src_row_size = 6'd26; src_col_size = 6'd26; relu_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w1.delete();
    w3.delete();
    chk("t7_write_low", {30'd0, dw1, dw3}, 32'd0);
    chk("t7_done_low", {30'd0, done1, done3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (done1 || done3 || dw1 || dw3) hi++;
    end
    chk("t7_quiet", hi + w1.size() + w3.size(), 32'd0);
    run(7, 1000, 26, 26, 1'b1, 0);
    build(3, 7, 1000, 26, 26, 1'b1); cmp("t8_u3", 3);
    build(1, 7, 1000, 26, 26, 1'b1); cmp("t8_u1", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
